// File: rtl/clock_pkg.sv
// ============================================================================
//  Module      : clock_pkg
//  Description : Shared state encoding and default parameters for clock_meter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package clock_pkg;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } meter_state_t;

    localparam int unsigned c_GATE_EDGES = 256;
    localparam int unsigned c_CNT_W      = 24;
    localparam int unsigned c_TIMEOUT    = 65535;
    localparam int unsigned c_EXPECT     = 8936;
    localparam int unsigned c_TOL        = 8;

endpackage

`default_nettype wire

// File: rtl/sync_edge.sv
// ============================================================================
//  Module      : sync_edge
//  Description : Two-flop synchronizer plus history flop; one-cycle rising-edge pulse.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_edge
    import clock_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_edge
);

    logic r_sync1;
    logic r_sync2;
    logic r_hist;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_hist  <= 1'b0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    assign o_edge = r_sync2 & ~r_hist;

endmodule

`default_nettype wire

// File: rtl/clock_meter.sv
// ============================================================================
//  Module      : clock_meter
//  Description : Measures GATE_EDGES periods of clk_in in clk_src cycles; lock/loss flags.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module clock_meter
    import clock_pkg::*;
#(
    parameter int unsigned GATE_EDGES = c_GATE_EDGES,
    parameter int unsigned CNT_W      = c_CNT_W,
    parameter int unsigned TIMEOUT    = c_TIMEOUT,
    parameter int unsigned EXPECT     = c_EXPECT,
    parameter int unsigned TOL        = c_TOL
) (
    input  logic             clk_src,
    input  logic             reset,
    input  logic             enable,
    input  logic             clk_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             lost
);

    localparam int unsigned c_EDGE_W = $clog2(GATE_EDGES);
    localparam int unsigned c_IDLE_W = $clog2(TIMEOUT + 1);

    localparam logic [c_EDGE_W-1:0] c_EDGE_LAST = c_EDGE_W'(GATE_EDGES - 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_MAX  = c_IDLE_W'(TIMEOUT);
    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]    c_EXPECT_V  = CNT_W'(EXPECT);
    localparam logic [CNT_W:0]      c_TOL_V     = (CNT_W + 1)'(TOL);

    // The cycle counter is never saturated; these bounds are what keep it from wrapping.
    generate
        if (GATE_EDGES < 2 || GATE_EDGES > 4096 ||
            (GATE_EDGES & (GATE_EDGES - 1)) != 0) begin : g_bad_gate_edges
            $error("clock_meter: GATE_EDGES must be a power of two in 2..4096");
        end
        if (TIMEOUT < 1 ||
            (64'(TIMEOUT) * 64'(GATE_EDGES)) >= (64'd1 << CNT_W)) begin : g_bad_timeout
            $error("clock_meter: TIMEOUT x GATE_EDGES must be below 2**CNT_W");
        end
    endgenerate

    meter_state_t          r_state;
    meter_state_t          w_state_nxt;
    logic [CNT_W-1:0]      r_cyc_cnt;
    logic [c_EDGE_W-1:0]   r_edge_cnt;
    logic [c_IDLE_W-1:0]   r_idle_cnt;
    logic [1:0]            r_streak;
    logic [CNT_W-1:0]      r_period;
    logic                  r_period_valid;
    logic                  r_locked;
    logic                  r_lost;

    logic                  w_edge;
    logic                  w_timeout;
    logic                  w_load;
    logic                  w_close;
    logic [CNT_W-1:0]      w_period_new;
    logic signed [CNT_W:0] w_diff;
    logic [CNT_W:0]        w_abs;
    logic                  w_in_tol;

    sync_edge u_sync_edge (
        .clk     (clk_src),
        .reset   (reset),
        .i_async (clk_in),
        .o_edge  (w_edge)
    );

    // An edge in the same cycle as the would-be timeout wins.
    assign w_timeout    = ~w_edge & (r_idle_cnt == c_IDLE_LAST);
    assign w_period_new = r_cyc_cnt + 1'b1;
    assign w_diff       = $signed({1'b0, w_period_new}) - $signed({1'b0, c_EXPECT_V});
    assign w_abs        = w_diff[CNT_W] ? $unsigned(-w_diff) : $unsigned(w_diff);
    assign w_in_tol     = (w_abs <= c_TOL_V);

    always_ff @(posedge clk_src) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_close     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (enable && w_edge) begin
                    w_state_nxt = ST_MEASURE;
                    w_load      = 1'b1;
                end
            end
            ST_MEASURE: begin
                if (!enable || w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_edge && (r_edge_cnt == c_EDGE_LAST)) begin
                    // Closing edge also opens the next window.
                    w_close = 1'b1;
                    w_load  = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_src) begin
        if (reset) begin
            r_cyc_cnt      <= '0;
            r_edge_cnt     <= '0;
            r_idle_cnt     <= '0;
            r_streak       <= 2'd0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_locked       <= 1'b0;
            r_lost         <= 1'b0;
        end else begin
            r_period_valid <= w_close;

            if (w_load) begin
                r_cyc_cnt  <= '0;
                r_edge_cnt <= '0;
            end else if (r_state == ST_MEASURE) begin
                r_cyc_cnt <= r_cyc_cnt + 1'b1;
                if (w_edge) begin
                    r_edge_cnt <= r_edge_cnt + 1'b1;
                end
            end

            if (w_edge) begin
                r_idle_cnt <= '0;
            end else if (r_idle_cnt != c_IDLE_MAX) begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end

            if (w_edge) begin
                r_lost <= 1'b0;
            end else if (w_timeout) begin
                r_lost <= 1'b1;
            end

            if (w_close) begin
                r_period <= w_period_new;
            end

            if (!enable || w_timeout) begin
                r_locked <= 1'b0;
                r_streak <= 2'd0;
            end else if (w_close) begin
                if (w_in_tol) begin
                    if (r_streak != 2'd2) begin
                        r_streak <= r_streak + 2'd1;
                    end
                    if (r_streak != 2'd0) begin
                        r_locked <= 1'b1;
                    end
                end else begin
                    r_streak <= 2'd0;
                    r_locked <= 1'b0;
                end
            end
        end
    end

    assign period       = r_period;
    assign period_valid = r_period_valid;
    assign locked       = r_locked;
    assign lost         = r_lost;

endmodule

`default_nettype wire

// File: tb/tb_clock_meter.sv
// ============================================================================
//  Module      : tb_clock_meter
//  Description : Self-checking bench for clock_meter against a window-sum reference model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_clock_meter;

    localparam int GE  = 4;
    localparam int CW  = 16;
    localparam int TO  = 100;
    localparam int EXP = 136;
    localparam int TL  = 2;
    // Rising edge on clk_in is registered by the meter three clk_src edges later.
    localparam int LAT = 3;

    logic          clk_src = 1'b0;
    logic          reset   = 1'b1;
    logic          enable  = 1'b0;
    logic          clk_in  = 1'b0;
    logic [CW-1:0] period;
    logic          period_valid;
    logic          locked;
    logic          lost;

    clock_meter #(
        .GATE_EDGES (GE),
        .CNT_W      (CW),
        .TIMEOUT    (TO),
        .EXPECT     (EXP),
        .TOL        (TL)
    ) dut (
        .clk_src      (clk_src),
        .reset        (reset),
        .enable       (enable),
        .clk_in       (clk_in),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .lost         (lost)
    );

    always #5 clk_src = ~clk_src;

    int cyc = 0;
    always @(posedge clk_src) cyc <= cyc + 1;

    typedef struct {
        int at;
        int per;
        bit lk;
    } win_t;

    win_t exp_q[$];
    bit   m_meas       = 1'b0;
    int   m_edges      = 0;
    int   m_acc        = 0;
    int   m_streak     = 0;
    int   m_last_per   = 0;
    int   m_last_rise  = 0;
    int   exp_lost_on  = -1;
    int   exp_lost_off = -1;
    bit   seen_lost_on = 1'b0;
    bit   prev_lost    = 1'b0;
    int   n_checks     = 0;
    int   n_pass       = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    // A window is the sum of GE consecutive clk_in periods starting at its opening edge.
    task automatic model_rise(input int p, input int at);
        m_last_rise = at;
        if (!enable) begin
            m_meas = 1'b0;
        end else if (!m_meas) begin
            m_meas  = 1'b1;
            m_edges = 0;
            m_acc   = p;
        end else begin
            m_edges++;
            if (m_edges == GE) begin
                win_t w;
                if (m_acc >= EXP - TL && m_acc <= EXP + TL) m_streak++;
                else m_streak = 0;
                w.at  = at + LAT;
                w.per = m_acc;
                w.lk  = (m_streak >= 2);
                exp_q.push_back(w);
                m_last_per = m_acc;
                m_edges    = 0;
                m_acc      = p;
            end else begin
                m_acc += p;
            end
        end
    endtask

    task automatic model_abort();
        m_meas   = 1'b0;
        m_streak = 0;
    endtask

    task automatic drive_period(input int p, input bit do_reset);
        for (int i = 0; i < p; i++) begin
            @(posedge clk_src);
            #1;
            clk_in = (i < p / 2);
            if (i == 0) model_rise(p, cyc);
            if (do_reset && i == p / 2 + 4) reset = 1'b1;
            if (do_reset && i == p / 2 + 5) begin
                reset = 1'b0;
                model_abort();
                m_last_per = 0;
                check("midrst_period", period, 0);
                check("midrst_valid", period_valid, 0);
                check("midrst_locked", locked, 0);
                check("midrst_lost", lost, 0);
            end
        end
    endtask

    always @(negedge clk_src) begin
        win_t w;
        if (exp_q.size() != 0 && exp_q[0].at == cyc) begin
            w = exp_q.pop_front();
            check("valid_pulse", period_valid, 1);
            check("period", period, w.per);
            check("locked_at_valid", locked, w.lk);
        end else if (period_valid !== 1'b0) begin
            check("valid_unexpected", period_valid, 0);
        end
        if (lost !== prev_lost) begin
            if (lost === 1'b1) begin
                seen_lost_on = 1'b1;
                check("lost_on_cycle", cyc, exp_lost_on);
                check("locked_on_loss", locked, 0);
            end else begin
                check("lost_off_cycle", cyc, exp_lost_off);
            end
        end
        prev_lost = lost;
    end

    initial begin
        repeat (3) @(posedge clk_src);
        #1;
        check("rst_period", period, 0);
        check("rst_valid", period_valid, 0);
        check("rst_locked", locked, 0);
        check("rst_lost", lost, 0);
        reset  = 1'b0;
        enable = 1'b1;

        // Steady div-34 input: three 136 windows, lock on the second.
        for (int k = 0; k < 13; k++) drive_period(34, 1'b0);
        // Slower periods push a window out of tolerance.
        for (int k = 0; k < 4; k++) drive_period(35, 1'b0);
        for (int k = 0; k < 4; k++) drive_period(34, 1'b0);
        // Alternating 34/35 gives 138 per window.
        for (int k = 0; k < 8; k++) drive_period(34 + (k % 2), 1'b0);
        for (int k = 0; k < 24; k++) drive_period(int'($urandom_range(36, 34)), 1'b0);

        // Drop enable mid-window, then re-enable.
        drive_period(34, 1'b0);
        drive_period(34, 1'b0);
        enable = 1'b0;
        model_abort();
        repeat (3) @(posedge clk_src);
        #1;
        check("dis_locked", locked, 0);
        check("dis_period_hold", period, m_last_per);
        for (int k = 0; k < 3; k++) drive_period(34, 1'b0);
        enable = 1'b1;
        for (int k = 0; k < 5; k++) drive_period(34, 1'b0);

        // Stop clk_in long enough to time out, then restart.
        drive_period(34, 1'b0);
        exp_lost_on = m_last_rise + LAT + TO;
        repeat (130) @(posedge clk_src);
        #1;
        model_abort();
        check("loss_lost", lost, 1);
        check("loss_locked", locked, 0);
        exp_lost_off = cyc + 1 + LAT;
        for (int k = 0; k < 6; k++) drive_period(34, 1'b0);

        // Reset in the middle of a window.
        drive_period(34, 1'b0);
        drive_period(34, 1'b1);
        for (int k = 0; k < 5; k++) drive_period(34, 1'b0);

        repeat (10) @(posedge clk_src);
        #1;
        check("pending_windows", exp_q.size(), 0);
        check("lost_seen", seen_lost_on, 1);
        check("final_lost", lost, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
